// File: rtl/alu4_op_issue_if.sv
// alu4_op_issue_if -- request/issue bus of alu4_op_issue.
//   master : upstream side (drives in_valid/in_op/in_a/in_b, observes the rest)
//   slave  : alu4_op_issue side
// Signals:
//   in_valid, in_ready, in_op[1:0], in_a[3:0], in_b[3:0]  request handshake
//   dec_enable, dec_select[1:0]                          2-to-4 decoder drive
//   opnd_a[3:0], opnd_b[3:0]                             operands of issued op
//   op_done, busy                                        completion / activity
interface alu4_op_issue_if;
   logic       in_valid;
   logic       in_ready;
   logic [1:0] in_op;
   logic [3:0] in_a;
   logic [3:0] in_b;
   logic       dec_enable;
   logic [1:0] dec_select;
   logic [3:0] opnd_a;
   logic [3:0] opnd_b;
   logic       op_done;
   logic       busy;

   modport master (
      output in_valid, in_op, in_a, in_b,
      input  in_ready, dec_enable, dec_select, opnd_a, opnd_b, op_done, busy
   );

   modport slave (
      input  in_valid, in_op, in_a, in_b,
      output in_ready, dec_enable, dec_select, opnd_a, opnd_b, op_done, busy
   );
endinterface

// File: rtl/alu4_op_issue.sv
// alu4_op_issue -- accepts 2-bit op + two 4-bit operands, issues each op to a
// 2-to-4 decoder for one cycle; op 2'b11 is followed by HOLD_CYCLES hold cycles.
// Ports:
//   clk    : clock, rising edge
//   rst_n  : asynchronous active-low reset
//   bus    : alu4_op_issue_if.slave (handshake, decoder drive, operands, status)
// Parameter:
//   HOLD_CYCLES : extra cycles after issue of op 2'b11 (1..15), default 3
// Configuration:
//   ALU4_ISSUE_FIFO_EN defined   -> 2-entry request FIFO, in_ready = not full
//   ALU4_ISSUE_FIFO_EN undefined -> single holding register, in_ready = empty
//                                   or being popped this cycle
module alu4_op_issue #(
   parameter int unsigned HOLD_CYCLES = 3
) (
   input  logic           clk,
   input  logic           rst_n,
   alu4_op_issue_if.slave bus
);

   typedef enum logic [1:0] {IDLE, ISSUE, HOLD} state_t;

   typedef struct packed {
      logic [1:0] op;
      logic [3:0] a;
      logic [3:0] b;
   } req_t;

   state_t     state, state_nx;
   req_t       in_req;
   req_t       head;
   req_t       iss;
   logic       stored;
   logic       push;
   logic       pop;
   logic [3:0] cnt;

   assign in_req = {bus.in_op, bus.in_a, bus.in_b};
   assign push   = bus.in_valid && bus.in_ready;

`ifdef ALU4_ISSUE_FIFO_EN
   req_t       mem [2];
   logic       wp, rp;
   logic [1:0] count;

   assign stored       = (count != 2'd0);
   assign head         = mem[rp];
   assign bus.in_ready = (count != 2'd2);

   // Storage array carries no reset; occupancy is tracked by count.
   always_ff @(posedge clk) begin
      if (push) mem[wp] <= in_req;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wp    <= 1'b0;
         rp    <= 1'b0;
         count <= 2'd0;
      end else begin
         if (push) wp <= ~wp;
         if (pop)  rp <= ~rp;
         unique case ({push, pop})
            2'b10:   count <= count + 2'd1;
            2'b01:   count <= count - 2'd1;
            default: count <= count;
         endcase
      end
   end
`else
   req_t hreg;
   logic hvalid;

   assign stored       = hvalid;
   assign head         = hreg;
   // A register being popped this cycle can be refilled on the same edge.
   assign bus.in_ready = !hvalid || pop;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         hreg   <= '0;
         hvalid <= 1'b0;
      end else if (push) begin
         hreg   <= in_req;
         hvalid <= 1'b1;
      end else if (pop) begin
         hvalid <= 1'b0;
      end
   end
`endif

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nx;
   end

   // Next state; pop is decided here since every pop coincides with entry
   // into ISSUE.
   always_comb begin
      state_nx = state;
      pop      = 1'b0;
      unique case (state)
         IDLE: begin
            if (stored) begin
               pop      = 1'b1;
               state_nx = ISSUE;
            end
         end
         ISSUE: begin
            if (iss.op == 2'b11) begin
               state_nx = HOLD;
            end else if (stored) begin
               pop      = 1'b1;
               state_nx = ISSUE;
            end else begin
               state_nx = IDLE;
            end
         end
         HOLD: begin
            if (cnt == 4'd0) begin
               if (stored) begin
                  pop      = 1'b1;
                  state_nx = ISSUE;
               end else begin
                  state_nx = IDLE;
               end
            end
         end
         default: state_nx = IDLE;
      endcase
   end

   // Issue registers and hold counter
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         iss <= '0;
         cnt <= 4'd0;
      end else begin
         if (pop) iss <= head;
         if (state == ISSUE && iss.op == 2'b11)
            cnt <= 4'(HOLD_CYCLES - 1);
         else if (state == HOLD && cnt != 4'd0)
            cnt <= cnt - 4'd1;
      end
   end

   // Outputs
   always_comb begin
      bus.dec_enable = (state == ISSUE);
      bus.op_done    = (state == ISSUE && iss.op != 2'b11) ||
                       (state == HOLD && cnt == 4'd0);
      bus.busy       = (state != IDLE);
   end

   // Issue registers only change on pop, so these hold between issues.
   assign bus.dec_select = iss.op;
   assign bus.opnd_a     = iss.a;
   assign bus.opnd_b     = iss.b;

endmodule

// File: tb/tb_alu4_op_issue.sv
module tb_alu4_op_issue;
   localparam int HC = 3;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   alu4_op_issue_if bus();

   alu4_op_issue #(.HOLD_CYCLES(HC)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   // Each accepted request with the cycle it must issue in and finish in.
   typedef struct {
      int op;
      int a;
      int b;
      int issue;
      int done;
   } exp_t;

   exp_t sb[$];
   int   cyc = 0;
   int   n_vec = 0;
   int   n_err = 0;
   int   last_done = -10;
   int   last_op = 0, last_a = 0, last_b = 0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s cycle %0d: got %h, expected %h", name, cyc, act, exp);
      end
   endtask

   function automatic logic [15:0] outs(input bit with_rdy);
      return {2'b0, with_rdy ? bus.in_ready : 1'b0, bus.dec_enable, bus.dec_select,
              bus.opnd_a, bus.opnd_b, bus.op_done, bus.busy};
   endfunction

   // Storage holds requests accepted but not yet issued.
   function automatic bit model_ready(input int c);
      int st = 0;
`ifdef ALU4_ISSUE_FIFO_EN
      foreach (sb[i]) if (sb[i].issue > c) st++;
      return st < 2;
`else
      bit popping = 0;
      foreach (sb[i]) begin
         if (sb[i].issue > c)      st++;
         if (sb[i].issue == c + 1) popping = 1;
      end
      return (st == 0) || popping;
`endif
   endfunction

   // Monitor: compares all outputs every cycle against the scoreboard head.
   bit m_den, m_done, m_busy;
   always @(negedge clk) begin
      if (!rst_n) begin
         sb.delete();
         last_op = 0; last_a = 0; last_b = 0;
         check("reset_outputs", outs(1), {2'b0, 1'b1, 13'b0});
      end else begin
         m_den = 0; m_done = 0; m_busy = 0;
         if (sb.size() > 0) begin
            if (sb[0].issue == cyc) begin
               m_den  = 1;
               last_op = sb[0].op; last_a = sb[0].a; last_b = sb[0].b;
            end
            m_busy = (sb[0].issue <= cyc);
            m_done = (sb[0].done == cyc);
         end
         check("outputs", outs(0), {3'b0, m_den, 2'(last_op), 4'(last_a), 4'(last_b),
                                    m_done, m_busy});
         if (m_done) void'(sb.pop_front());
      end
   end

   task automatic drive(input bit v, input int op, input int a, input int b, output bit acc);
      bit er;
      int iss;
      @(negedge clk);
      bus.in_valid = v;
      bus.in_op    = 2'(op);
      bus.in_a     = 4'(a);
      bus.in_b     = 4'(b);
      er = model_ready(cyc);
      check("in_ready", {15'b0, bus.in_ready}, {15'b0, er});
      acc = v && er;
      if (acc) begin
         // Accepted at edge cyc+1; issue waits for that edge and for the previous op.
         iss = (cyc + 2 > last_done + 1) ? cyc + 2 : last_done + 1;
         last_done = iss + ((op == 3) ? HC : 0);
         sb.push_back('{op, a, b, iss, last_done});
      end
   endtask

   task automatic send(input int op, input int a, input int b);
      bit acc = 0;
      int t = 0;
      while (!acc && t < 50) begin
         drive(1, op, a, b, acc);
         t++;
      end
      if (!acc) begin
         n_vec++;
         n_err++;
         $display("FAIL send_timeout op=%0d: got no accept, required accept within 50 cycles", op);
      end
   endtask

   task automatic idle(input int n);
      bit acc;
      repeat (n) drive(0, 0, 0, 0, acc);
   endtask

   initial begin
      bit acc;
      bit have;
      int rop, ra, rb;
      bus.in_valid = 0;
      bus.in_op    = 0;
      bus.in_a     = 0;
      bus.in_b     = 0;
      rst_n = 0;
      repeat (2) @(posedge clk);
      #2 rst_n = 1;

      send(1, 4'h3, 4'h5);                       // single short op
      idle(4);
      send(3, 4'hA, 4'h6);                       // long op
      idle(8);
      send(0, 1, 2); send(1, 3, 4); send(2, 5, 6); // back-to-back
      idle(6);
      send(3, 7, 7); send(1, 8, 9); send(2, 9, 8); // backpressure
      idle(12);

      // Reset in the second hold cycle of an op-3 sequence
      send(3, 2, 2);
      @(posedge clk);                            // accept edge
      #1 bus.in_valid = 0;
      @(posedge clk);                            // issue cycle
      @(posedge clk);                            // first hold cycle
      @(posedge clk);                            // second hold cycle
      #2 rst_n = 0;
      #1 check("async_reset", outs(1), {2'b0, 1'b1, 13'b0});
      last_done = -10;
      @(posedge clk);
      @(posedge clk);
      #2 rst_n = 1;
      send(2, 4'hF, 4'h1);                       // accept on first edge after release
      idle(4);

      have = 0; rop = 0; ra = 0; rb = 0;
      for (int i = 0; i < 400; i++) begin
         if (!have && $urandom_range(0, 99) < 60) begin
            have = 1;
            rop  = int'($urandom_range(0, 3));
            ra   = int'($urandom_range(0, 15));
            rb   = int'($urandom_range(0, 15));
         end
         drive(have, rop, ra, rb, acc);
         if (acc) have = 0;
      end
      idle(12);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule

// File: doc/alu4_op_issue.md
ALU4_OP_ISSUE -- requirements
Module: alu4_op_issue

Interface
REQ-001 Parameter: HOLD_CYCLES, default 3, extra hold cycles after issue for op 2'b11; legal range 1..15.
REQ-002 Clock is clk, input, 1 bit; the single clock, and all state updates on its rising edge.
REQ-003 Reset is rst_n, input, 1 bit; asynchronous, active-low.
REQ-004 in_valid, input, 1 bit: upstream request valid.
REQ-005 in_ready, output, 1 bit: block can accept a request this cycle.
REQ-006 in_op, input, 2 bits: operation code.
REQ-007 in_a, in_b, input, 4 bits each: operands.
REQ-008 dec_enable, output, 1 bit: drives the 2-to-4 decoder enable.
REQ-009 dec_select, output, 2 bits: drives the decoder select.
REQ-010 opnd_a, opnd_b, output, 4 bits each: operands of the op being issued, stable while busy.
REQ-011 op_done, output, 1 bit: one-cycle pulse on the last cycle of each op.
REQ-012 busy, output, 1 bit: high in ISSUE or HOLD.

Function
REQ-013 A request is accepted on a rising edge where in_valid and in_ready are both 1; op, a and b are captured together.
REQ-014 The FSM has three states: IDLE, ISSUE and HOLD.
REQ-015 IDLE: if a stored request exists, pop it into the issue registers and enter ISSUE on the next edge.
REQ-016 ISSUE lasts exactly one cycle: dec_enable=1 and dec_select=issued op.
REQ-017 In every other state dec_enable=0 and dec_select holds its last value.
REQ-018 ISSUE with op 0..2: op_done=1 in the ISSUE cycle.
REQ-019 ISSUE with op 0..2, next state: ISSUE with the next stored request if one exists (back-to-back, no bubble), else IDLE.
REQ-020 ISSUE with op 3: next state is HOLD; the counter loads HOLD_CYCLES-1.
REQ-021 HOLD: the counter decrements each cycle; op_done=1 on the cycle it equals 0.
REQ-022 HOLD, next state: ISSUE if a request is stored, else IDLE.
REQ-023 Latency for op 0..2: an accept at edge N, with the FSM idle and storage empty, gives dec_enable=1 and op_done=1 in cycle N+1.
REQ-024 Latency for op 3: op_done rises in cycle N+1+HOLD_CYCLES.
REQ-025 opnd_a and opnd_b update only when a request is popped into ISSUE.
REQ-026 Accept and pop in the same cycle are both honoured: storage occupancy is unchanged and no request is lost or duplicated.
REQ-027 in_valid while in_ready=0 has no effect; no request is dropped, and upstream holds it.
REQ-028 busy = (state != IDLE).

Reset
REQ-029 While rst_n=0, all outputs are forced immediately, independent of clk: state=IDLE, storage empty, counter=0, dec_enable=0, dec_select=0, opnd_a=0, opnd_b=0, op_done=0, busy=0, in_ready=1.
REQ-030 Reset asserted mid-op (ISSUE or HOLD) aborts the op: no op_done is produced, and stored requests are discarded.
REQ-031 The first accept after release can occur on the first rising edge with rst_n=1.

Configuration
REQ-032 Macro ALU4_ISSUE_FIFO_EN selects the storage mode.
REQ-033 With ALU4_ISSUE_FIFO_EN defined: storage is a 2-entry FIFO, in_ready = not full, requests are popped in order, and pointers wrap modulo 2.
REQ-034 Without ALU4_ISSUE_FIFO_EN: storage is a single holding register, and in_ready = (register empty) or (register popped this cycle).

Verification
REQ-035 Reset then single op: op=2'b01, a=4'h3, b=4'h5 accepted at edge 1 -> cycle 2 dec_enable=1, dec_select=01, opnd_a=3, opnd_b=5, op_done=1; cycle 3 back to IDLE.
REQ-036 Long op with HOLD_CYCLES=3: op=2'b11 accepted at edge 1 -> dec_enable=1 only in cycle 2, op_done only in cycle 5, busy in cycles 2..5.
REQ-037 Back-to-back: ops 0,1,2 presented on consecutive cycles with the FIFO enabled -> dec_select=0,1,2 in cycles 2,3,4, dec_enable high continuously, 3 op_done pulses.
REQ-038 Full/backpressure with the FIFO enabled: op 3, then ops 1 and 2 held valid -> in_ready=0 while 2 entries are stored, no loss, ops issued in order 3,1,2.
REQ-039 Reset mid-HOLD: rst_n driven low during cycle 3 of an op-3 sequence -> outputs go to reset values before the next edge, with no op_done.
REQ-040 Simultaneous accept and pop with a single register (macro undefined) -> in_ready stays 1 and an op is issued every cycle.
